exu_lsu: RTL and testbench

Parametrised load/store unit replacing the single-cycle word-only memory path in the execute stage. It accepts one load or store per valid/ready handshake and supports byte, half, word and (XLEN=64) double accesses with sign or zero extension. It drives a word-aligned memory port with a byte write mask, waits for a memory acknowledge, then returns the result on a valid/ready response channel.
Misaligned and illegal accesses are reported as errors without touching memory.

---
 rtl/exu_lsu_if.sv | 50 +++++
 rtl/exu_lsu.sv | 187 ++++++++++++++++++
 tb/tb_exu_lsu.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_lsu_if.sv
// Load/store unit bus bundle: request channel, response channel and word-aligned memory port.
// Latency: none (signal bundle only).
// Backpressure: valid/ready on request and response; memory side completes on mem_ack.
interface exu_lsu_if #(
    parameter int XLEN = 32
);
    // Request channel (execute stage -> LSU)
    logic              req_valid;
    logic              req_ready;
    logic              req_is_load;
    logic              req_is_store;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;

    // Response channel (LSU -> execute stage)
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    // Memory port (LSU -> memory)
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wmask;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    // LSU view
    modport slave (
        input  req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_addr, mem_wdata, mem_wmask, mem_r_en, mem_w_en,
        input  mem_ack, mem_rdata
    );

    // Environment view (execute stage plus memory)
    modport master (
        output req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_addr, mem_wdata, mem_wmask, mem_r_en, mem_w_en,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/exu_lsu.sv
// Load/store unit: byte/half/word(/double) accesses with extension over a word-aligned memory port.
// Latency: error/no-op 1 cycle to response; memory access strobes next cycle, response 1 cycle after mem_ack.
// Backpressure: one transaction in flight; req_ready low until the response handshakes. Optional LSU_TIMEOUT_EN adds an ack watchdog.
module exu_lsu #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic     clk,
    input  logic     rst,
    exu_lsu_if.slave bus
);
    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("exu_lsu: XLEN must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("exu_lsu: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state;
    logic [2:0]      f3_q;
    logic [LW-1:0]   lane_q;

    logic [LW-1:0]   req_lane;
    logic            f3_legal;
    logic            misaligned;
    logic            req_err;
    logic            req_mem;
    logic [NB-1:0]   mask_base;
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_data;
    logic            tmo_hit;

    assign req_lane = bus.req_addr[LW-1:0];

    // Sign or zero extend the low access-size bytes of d according to funct3.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [2:0] f3);
        logic [XLEN-1:0] r;
        r = d;
        case (f3[1:0])
            2'b00: if (f3[2]) r = XLEN'(d[7:0]);  else r = XLEN'($signed(d[7:0]));
            2'b01: if (f3[2]) r = XLEN'(d[15:0]); else r = XLEN'($signed(d[15:0]));
            2'b10: if (f3[2]) r = XLEN'(d[31:0]); else r = XLEN'($signed(d[31:0]));
            default: r = d;
        endcase
        return r;
    endfunction

    // Classify the offered request: legal size code, natural alignment, error vs memory access.
    always_comb begin
        f3_legal = 1'b0;
        if (bus.req_is_store) begin
            case (bus.req_funct3)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                3'b011:                 f3_legal = (XLEN == 64);
                default:                f3_legal = 1'b0;
            endcase
        end else begin
            case (bus.req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                3'b011, 3'b110:                         f3_legal = (XLEN == 64);
                default:                                f3_legal = 1'b0;
            endcase
        end
        case (bus.req_funct3[1:0])
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = |bus.req_addr[1:0];
            2'b11:   misaligned = |bus.req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
        req_err = (bus.req_is_load && bus.req_is_store)
                || ((bus.req_is_load ^ bus.req_is_store) && (!f3_legal || misaligned));
        req_mem = (bus.req_is_load ^ bus.req_is_store) && f3_legal && !misaligned;
    end

    // Unshifted byte-enable pattern: access-size ones starting at lane 0.
    always_comb begin
        mask_base = '0;
        for (int i = 0; i < NB; i++) begin
            mask_base[i] = (i < (1 << bus.req_funct3[1:0]));
        end
    end

    // Align the returned word to the accessed bytes and extend.
    always_comb begin
        ld_shift = bus.mem_rdata >> {lane_q, 3'b000};
        ld_data  = extend(ld_shift, f3_q);
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // The final ack-less ACCESS cycle is the one where the count hits TIMEOUT_CYCLES-1.
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Count ACCESS cycles without an acknowledge; restart on every accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !bus.mem_ack) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            f3_q           <= '0;
            lane_q         <= '0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_wmask  <= '0;
            bus.mem_r_en   <= 1'b0;
            bus.mem_w_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        f3_q          <= bus.req_funct3;
                        lane_q        <= req_lane;
                        if (req_mem) begin
                            state         <= ACCESS;
                            bus.mem_addr  <= {bus.req_addr[XLEN-1:LW], {LW{1'b0}}};
                            bus.mem_r_en  <= bus.req_is_load;
                            bus.mem_w_en  <= bus.req_is_store;
                            bus.mem_wdata <= bus.req_is_store ? (bus.req_wdata << {req_lane, 3'b000}) : '0;
                            bus.mem_wmask <= bus.req_is_store ? (mask_base << req_lane) : '0;
                        end else begin
                            // Errors and no-ops complete without touching memory.
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= req_err;
                            bus.resp_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack) begin
                        state          <= RESP;
                        bus.mem_r_en   <= 1'b0;
                        bus.mem_w_en   <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= bus.mem_r_en ? ld_data : '0;
                    end else if (tmo_hit) begin
                        state          <= RESP;
                        bus.mem_r_en   <= 1'b0;
                        bus.mem_w_en   <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.resp_rdata <= '0;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.req_ready  <= 1'b1;
                        bus.resp_valid <= 1'b0;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= '0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exu_lsu.sv
// Bench for exu_lsu at XLEN=32: directed table, randomized traffic against a byte-level model, and corner sequences.
// Latency: checks strobe/response timing relative to acceptance.
// Backpressure: varies mem_ack delay and resp_ready stalls.
module tb_exu_lsu;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exu_lsu_if #(.XLEN(XLEN)) b();
    exu_lsu #(.XLEN(XLEN), .TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(b));

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        bit          mem;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } exp_t;

    typedef struct {
        bit          tmo, err, saw_r, saw_w, both, stable, rdy_busy, rv_stable, ready_after;
        logic [31:0] rdata, addr, wdata;
        logic [3:0]  wmask;
        int          sc, first_k, resp_lat, rv_cnt;
    } res_t;

    typedef struct {
        bit          ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, mrd;
        bit          err;
        logic [31:0] rdata;
        bit          mem;
        logic [31:0] maddr, mwdata;
        logic [3:0]  mwmask;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: architectural byte-lane semantics of a RISC-V load/store on a 4-byte word.
    function automatic exp_t model(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] mrd);
        exp_t   e;
        int     sz;
        int     lane;
        bit     legal;
        longint v;
        e = '{default: 0};
        sz = 1 << f3[1:0];
        lane = int'(addr[1:0]);
        if (ld && st) begin
            e.err = 1'b1;
        end else if (ld || st) begin
            legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            if (!legal || (int'(addr[2:0]) % sz) != 0) begin
                e.err = 1'b1;
            end else begin
                e.mem  = 1'b1;
                e.wr   = st;
                e.addr = addr - 32'(lane);
                if (st) begin
                    e.wdata = 32'(longint'(wdata) << (8 * lane));
                    for (int i = 0; i < sz; i++) e.wmask[lane + i] = 1'b1;
                end else begin
                    v = 0;
                    for (int i = 0; i < sz; i++)
                        v = v | (((longint'(mrd) >> (8 * (lane + i))) & 64'hFF) << (8 * i));
                    if (!f3[2] && (((v >> (8 * sz - 1)) & 1) != 0))
                        v = v - (longint'(1) << (8 * sz));
                    e.rdata = v[31:0];
                end
            end
        end
        return e;
    endfunction

    // Offer one request and play memory/consumer until the response handshakes or the budget runs out.
    task automatic run_txn(input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mrd,
                           input int ack_dly, input int resp_dly, input int budget,
                           input bit late_ack, output res_t r);
        bit got;
        bit hs;
        r = '{default: 0};
        r.tmo = 1'b1; r.stable = 1'b1; r.rdy_busy = 1'b1; r.rv_stable = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (b.req_ready) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) return;
        b.req_valid = 1'b1; b.req_is_load = ld; b.req_is_store = st;
        b.req_funct3 = f3; b.req_addr = addr; b.req_wdata = wdata;
        @(posedge clk); #1;
        b.req_valid = 1'b0;
        b.req_addr = $urandom; b.req_wdata = $urandom;
        for (int k = 1; k <= budget; k++) begin
            b.mem_rdata = $urandom;
            if (b.req_ready) r.rdy_busy = 1'b0;
            if (b.mem_r_en && b.mem_w_en) r.both = 1'b1;
            if (b.mem_r_en || b.mem_w_en) begin
                if (b.mem_r_en) r.saw_r = 1'b1;
                if (b.mem_w_en) r.saw_w = 1'b1;
                if (r.sc == 0) begin
                    r.first_k = k; r.addr = b.mem_addr; r.wdata = b.mem_wdata; r.wmask = b.mem_wmask;
                end else if (b.mem_addr !== r.addr || b.mem_wdata !== r.wdata || b.mem_wmask !== r.wmask) begin
                    r.stable = 1'b0;
                end
                r.sc++;
                if (r.sc > ack_dly) begin b.mem_ack = 1'b1; b.mem_rdata = mrd; end
            end
            if (b.resp_valid) begin
                if (r.rv_cnt == 0) begin
                    r.resp_lat = k; r.err = b.resp_err; r.rdata = b.resp_rdata;
                end else if (b.resp_err !== r.err || b.resp_rdata !== r.rdata) begin
                    r.rv_stable = 1'b0;
                end
                r.rv_cnt++;
                if (r.rv_cnt > resp_dly) b.resp_ready = 1'b1;
                if (late_ack) begin b.mem_ack = 1'b1; b.mem_rdata = 32'hFFFF_FFFF; end
            end
            @(posedge clk); #1;
            hs = b.resp_ready;
            b.mem_ack = 1'b0; b.resp_ready = 1'b0;
            if (hs) begin
                r.ready_after = b.req_ready;
                r.tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_txn(input string tag, input exp_t e, input res_t r, input int ack_dly);
        chk({tag, ".done"}, r.tmo, 0);
        chk({tag, ".err"}, r.err, e.err);
        chk({tag, ".rdata"}, r.rdata, e.rdata);
        chk({tag, ".r_en"}, r.saw_r, e.mem && !e.wr);
        chk({tag, ".w_en"}, r.saw_w, e.mem && e.wr);
        chk({tag, ".both_strobes"}, r.both, 0);
        chk({tag, ".mem_stable"}, r.stable, 1);
        chk({tag, ".resp_stable"}, r.rv_stable, 1);
        chk({tag, ".ready_busy"}, r.rdy_busy, 1);
        chk({tag, ".ready_after"}, r.ready_after, 1);
        if (e.mem) begin
            chk({tag, ".mem_addr"}, r.addr, e.addr);
            chk({tag, ".wmask"}, r.wmask, e.wmask);
            if (e.wr) chk({tag, ".wdata"}, r.wdata, e.wdata);
            chk({tag, ".strobe_lat"}, r.first_k, 1);
            chk({tag, ".strobe_cycles"}, r.sc, ack_dly + 1);
            chk({tag, ".resp_lat"}, r.resp_lat, ack_dly + 2);
        end else begin
            chk({tag, ".strobe_cycles"}, r.sc, 0);
            chk({tag, ".resp_lat"}, r.resp_lat, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t  tv[16];
        exp_t  e;
        res_t  r;
        int    cnt;
        bit    ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, mrd;
        int    sel, ad, rd;

        b.req_valid = 1'b0; b.req_is_load = 1'b0; b.req_is_store = 1'b0; b.req_funct3 = '0;
        b.req_addr = '0; b.req_wdata = '0; b.resp_ready = 1'b0; b.mem_ack = 1'b0; b.mem_rdata = '0;

        //        ld st f3    addr           wdata          mrd            err rdata          mem maddr          mwdata         mask
        tv[0]  = '{0, 1, 3'd0, 32'h8000_0003, 32'h0000_00AB, 32'h0,         0, 32'h0,         1, 32'h8000_0000, 32'hAB00_0000, 4'b1000};
        tv[1]  = '{1, 0, 3'd1, 32'h8000_0002, 32'h0,         32'h8001_1234, 0, 32'hFFFF_8001, 1, 32'h8000_0000, 32'h0,         4'b0000};
        tv[2]  = '{1, 0, 3'd5, 32'h8000_0002, 32'h0,         32'h8001_1234, 0, 32'h0000_8001, 1, 32'h8000_0000, 32'h0,         4'b0000};
        tv[3]  = '{1, 0, 3'd0, 32'h8000_0000, 32'h0,         32'h8001_1234, 0, 32'h0000_0034, 1, 32'h8000_0000, 32'h0,         4'b0000};
        tv[4]  = '{1, 0, 3'd2, 32'h8000_0006, 32'h0,         32'h1234_5678, 1, 32'h0,         0, 32'h0,         32'h0,         4'b0000};
        tv[5]  = '{0, 1, 3'd1, 32'h0000_0001, 32'h5555_5555, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         4'b0000};
        tv[6]  = '{1, 1, 3'd2, 32'h0000_0000, 32'h0,         32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         4'b0000};
        tv[7]  = '{1, 0, 3'd3, 32'h0000_0000, 32'h0,         32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         4'b0000};
        tv[8]  = '{0, 1, 3'd4, 32'h0000_0000, 32'h0,         32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         4'b0000};
        tv[9]  = '{0, 0, 3'd7, 32'h0000_0003, 32'h0,         32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         4'b0000};
        tv[10] = '{0, 1, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,         0, 32'h0,         1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111};
        tv[11] = '{1, 0, 3'd4, 32'h0000_0101, 32'h0,         32'h0000_F200, 0, 32'h0000_00F2, 1, 32'h0000_0100, 32'h0,         4'b0000};
        tv[12] = '{1, 0, 3'd0, 32'h0000_0101, 32'h0,         32'h0000_F200, 0, 32'hFFFF_FFF2, 1, 32'h0000_0100, 32'h0,         4'b0000};
        tv[13] = '{0, 1, 3'd1, 32'h0000_0012, 32'h1234_5678, 32'h0,         0, 32'h0,         1, 32'h0000_0010, 32'h5678_0000, 4'b1100};
        tv[14] = '{1, 0, 3'd2, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1, 32'h0000_0008, 32'h0,         4'b0000};
        tv[15] = '{1, 0, 3'd6, 32'h0000_0000, 32'h0,         32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         4'b0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req_ready", b.req_ready, 0);
        chk("rst.resp_valid", b.resp_valid, 0);
        chk("rst.mem_r_en", b.mem_r_en, 0);
        chk("rst.mem_w_en", b.mem_w_en, 0);
        chk("rst.mem_wmask", b.mem_wmask, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst.req_ready", b.req_ready, 1);

        // Directed table
        foreach (tv[i]) begin
            e = '{default: 0};
            e.err = tv[i].err; e.rdata = tv[i].rdata; e.mem = tv[i].mem; e.wr = tv[i].st;
            e.addr = tv[i].maddr; e.wdata = tv[i].mwdata; e.wmask = tv[i].mwmask;
            run_txn(tv[i].ld, tv[i].st, tv[i].f3, tv[i].addr, tv[i].wdata, tv[i].mrd, i % 3, i % 2, 40, 1'b0, r);
            check_txn($sformatf("tv%0d", i), e, r, i % 3);
        end

        // Long ack delay with response backpressure
        run_txn(1'b1, 1'b0, 3'd2, 32'h0000_0044, 32'h0, 32'h5566_7788, 4, 3, 40, 1'b0, r);
        e = model(1'b1, 1'b0, 3'd2, 32'h0000_0044, 32'h0, 32'h5566_7788);
        check_txn("stall", e, r, 4);
        chk("stall.resp_cycles", r.rv_cnt, 4);

        // Reset in the middle of a load access
        b.req_valid = 1'b1; b.req_is_load = 1'b1; b.req_is_store = 1'b0;
        b.req_funct3 = 3'd2; b.req_addr = 32'h0000_0080;
        @(posedge clk); #1;
        b.req_valid = 1'b0;
        chk("rstmid.r_en_before", b.mem_r_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.r_en", b.mem_r_en, 0);
        chk("rstmid.resp_valid", b.resp_valid, 0);
        chk("rstmid.req_ready", b.req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (b.resp_valid || b.mem_r_en) cnt++;
            if (k == 0) chk("rstmid.ready_after", b.req_ready, 1);
        end
        chk("rstmid.no_resp", cnt, 0);
        run_txn(1'b0, 1'b1, 3'd2, 32'h0000_0020, 32'h0BAD_F00D, 32'h0, 1, 0, 40, 1'b0, r);
        e = model(1'b0, 1'b1, 3'd2, 32'h0000_0020, 32'h0BAD_F00D, 32'h0);
        check_txn("rstmid.sw", e, r, 1);

        // Missing acknowledge
`ifdef LSU_TIMEOUT_EN
        run_txn(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'h1357_9BDF, 1000, 2, 60, 1'b1, r);
        chk("tmo.done", r.tmo, 0);
        chk("tmo.strobe_cycles", r.sc, 16);
        chk("tmo.err", r.err, 1);
        chk("tmo.rdata", r.rdata, 0);
        chk("tmo.resp_lat", r.resp_lat, 17);
        chk("tmo.late_ack", r.rv_stable, 1);
        chk("tmo.ready_after", r.ready_after, 1);
`else
        b.req_valid = 1'b1; b.req_is_load = 1'b1; b.req_is_store = 1'b0;
        b.req_funct3 = 3'd2; b.req_addr = 32'h0000_0100;
        @(posedge clk); #1;
        b.req_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 120; k++) begin
            if (b.mem_r_en && !b.resp_valid && !b.req_ready) cnt++;
            @(posedge clk); #1;
        end
        chk("noack.wait_cycles", cnt, 120);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            ld = (sel == 0) || (sel >= 2 && sel <= 5);
            st = (sel == 0) || (sel >= 6);
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom; wdata = $urandom; mrd = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            ad = $urandom_range(0, 3);
            rd = $urandom_range(0, 2);
            run_txn(ld, st, f3, addr, wdata, mrd, ad, rd, 40, 1'b0, r);
            e = model(ld, st, f3, addr, wdata, mrd);
            check_txn($sformatf("rnd%0d", n), e, r, ad);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
